// File: rtl/drlp_pkg.sv
// drlp_pkg
//   Shared definitions for the PE-array downstream stages.
//   Contents:
//     DATA_WIDTH_DEF  default output activation width
//     PSUM_WIDTH_DEF  default PE total-sum width (2*DATA_WIDTH_DEF+6)
//     ACC_WIDTH_DEF   default internal accumulator width
//     acc_state_e     accumulator FSM states (ST_ACC, ST_HOLD)
//     sat_max/sat_min signed saturation bounds for a given output width
package drlp_pkg;

  localparam int DATA_WIDTH_DEF = 8;
  localparam int PSUM_WIDTH_DEF = DATA_WIDTH_DEF * 2 + 6;
  localparam int ACC_WIDTH_DEF  = 32;

  typedef enum logic {
    ST_ACC  = 1'b0,
    ST_HOLD = 1'b1
  } acc_state_e;

  // Largest value representable in a w-bit two's complement word.
  function automatic longint sat_max(int w);
    return (longint'(1) <<< (w - 1)) - longint'(1);
  endfunction

  // Smallest value representable in a w-bit two's complement word.
  function automatic longint sat_min(int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

endpackage

// File: rtl/requant_sat.sv
// requant_sat
//   Purely combinational requantizer: round-half-up, arithmetic right
//   shift, saturation to DATA_WIDTH, and optional rectification.
//   Optional feature macro: PSUM_ACC_RELU_EN (negative results forced to 0).
//   Ports:
//     acc_in    signed accumulated sum (ACC_WIDTH)
//     shift_in  right-shift amount (SHIFT_WIDTH)
//     data_out  signed saturated result (DATA_WIDTH)
module requant_sat
  import drlp_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic signed [ACC_WIDTH-1:0]   acc_in,
  input  logic        [SHIFT_WIDTH-1:0] shift_in,
  output logic signed [DATA_WIDTH-1:0]  data_out
);

  localparam logic signed [ACC_WIDTH:0] SAT_HI = (ACC_WIDTH + 1)'(sat_max(DATA_WIDTH));
  localparam logic signed [ACC_WIDTH:0] SAT_LO = (ACC_WIDTH + 1)'(sat_min(DATA_WIDTH));

  logic signed [ACC_WIDTH:0]    x_ext;
  logic signed [ACC_WIDTH:0]    rounded;
  logic signed [ACC_WIDTH:0]    shifted;
  logic signed [DATA_WIDTH-1:0] clamped;

  // The rounding add uses one extra bit so a sum near the positive limit
  // cannot wrap before the shift.
  always_comb begin
    x_ext   = {acc_in[ACC_WIDTH-1], acc_in};
    rounded = x_ext;
    shifted = x_ext;
    if (shift_in != '0) begin
      rounded = x_ext + ((ACC_WIDTH + 1)'(1) << (shift_in - SHIFT_WIDTH'(1)));
      shifted = rounded >>> shift_in;
    end

    if (shifted > SAT_HI) begin
      clamped = SAT_HI[DATA_WIDTH-1:0];
    end else if (shifted < SAT_LO) begin
      clamped = SAT_LO[DATA_WIDTH-1:0];
    end else begin
      clamped = shifted[DATA_WIDTH-1:0];
    end

`ifdef PSUM_ACC_RELU_EN
    if (clamped[DATA_WIDTH-1]) begin
      clamped = '0;
    end
`endif

    data_out = clamped;
  end

endmodule

// File: rtl/psum_accumulator.sv
// psum_accumulator
//   Accumulates signed PE total sums over cfg_num_pass passes, then
//   requantizes (round, shift, saturate, optional ReLU) and presents the
//   result on a valid/ready output. Input is stalled while a result waits.
//   Optional feature macro: PSUM_ACC_RELU_EN (handled inside requant_sat).
//   Ports:
//     clk, rst_n               clock, asynchronous active-low reset
//     clear                    synchronous abort of partial group / pending output
//     cfg_num_pass, cfg_shift  group configuration, sampled on a group's first beat
//     in_valid/in_ready/in_psum   input beat handshake and data
//     out_valid/out_ready/out_data output result handshake and data
module psum_accumulator
  import drlp_pkg::*;
#(
  parameter int DATA_WIDTH  = DATA_WIDTH_DEF,
  parameter int PSUM_WIDTH  = DATA_WIDTH * 2 + 6,
  parameter int ACC_WIDTH   = ACC_WIDTH_DEF,
  parameter int PASS_WIDTH  = 8,
  parameter int SHIFT_WIDTH = 5
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clear,
  input  logic        [PASS_WIDTH-1:0]  cfg_num_pass,
  input  logic        [SHIFT_WIDTH-1:0] cfg_shift,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  logic signed [PSUM_WIDTH-1:0]  in_psum,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic signed [DATA_WIDTH-1:0]  out_data
);

  // The accumulator must hold the maximum pass count of full-scale sums.
  if (PSUM_WIDTH + PASS_WIDTH > ACC_WIDTH) begin : g_width_check
    $error("psum_accumulator: PSUM_WIDTH + PASS_WIDTH exceeds ACC_WIDTH");
  end

  acc_state_e state_q, state_d;

  logic        [PASS_WIDTH-1:0]  cnt_q, cnt_d;
  logic        [PASS_WIDTH-1:0]  num_q, num_d;
  logic        [SHIFT_WIDTH-1:0] shift_q, shift_d;
  logic signed [ACC_WIDTH-1:0]   acc_q, acc_d;
  logic signed [DATA_WIDTH-1:0]  out_data_q, out_data_d;

  logic                          first_beat;
  logic                          beat_accept;
  logic                          last_beat;
  logic        [PASS_WIDTH-1:0]  num_eff;
  logic        [SHIFT_WIDTH-1:0] shift_eff;
  logic signed [ACC_WIDTH-1:0]   psum_ext;
  logic signed [ACC_WIDTH-1:0]   sum;
  logic signed [DATA_WIDTH-1:0]  rq_data;

  // On a group's first beat the latched config is not yet updated, so the
  // live config inputs are used for that beat's decisions.
  always_comb begin
    first_beat  = (cnt_q == '0);
    beat_accept = (state_q == ST_ACC) && in_valid;
    num_eff     = num_q;
    shift_eff   = shift_q;
    if (first_beat) begin
      num_eff   = (cfg_num_pass == '0) ? PASS_WIDTH'(1) : cfg_num_pass;
      shift_eff = cfg_shift;
    end
    last_beat = (cnt_q == num_eff - PASS_WIDTH'(1));
    psum_ext  = {{(ACC_WIDTH - PSUM_WIDTH){in_psum[PSUM_WIDTH-1]}}, in_psum};
    sum       = (first_beat ? '0 : acc_q) + psum_ext;
  end

  requant_sat #(
    .DATA_WIDTH  (DATA_WIDTH),
    .ACC_WIDTH   (ACC_WIDTH),
    .SHIFT_WIDTH (SHIFT_WIDTH)
  ) u_requant_sat (
    .acc_in   (sum),
    .shift_in (shift_eff),
    .data_out (rq_data)
  );

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_ACC;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; clear overrides both a beat and a consumer handshake.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = ST_ACC;
    end else begin
      case (state_q)
        ST_ACC:  if (in_valid && last_beat) state_d = ST_HOLD;
        ST_HOLD: if (out_ready)             state_d = ST_ACC;
        default: state_d = ST_ACC;
      endcase
    end
  end

  // Handshake outputs decode only the registered state.
  always_comb begin
    in_ready  = (state_q == ST_ACC);
    out_valid = (state_q == ST_HOLD);
  end

  // Datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      num_q      <= PASS_WIDTH'(1);
      shift_q    <= '0;
      acc_q      <= '0;
      out_data_q <= '0;
    end else begin
      cnt_q      <= cnt_d;
      num_q      <= num_d;
      shift_q    <= shift_d;
      acc_q      <= acc_d;
      out_data_q <= out_data_d;
    end
  end

  // Datapath next values. acc is left stale at the end of a group because
  // the next first beat ignores it.
  always_comb begin
    cnt_d      = cnt_q;
    num_d      = num_q;
    shift_d    = shift_q;
    acc_d      = acc_q;
    out_data_d = out_data_q;
    if (clear) begin
      cnt_d = '0;
    end else if (beat_accept) begin
      if (first_beat) begin
        num_d   = num_eff;
        shift_d = cfg_shift;
      end
      if (last_beat) begin
        out_data_d = rq_data;
        cnt_d      = '0;
      end else begin
        acc_d = sum;
        cnt_d = cnt_q + PASS_WIDTH'(1);
      end
    end
  end

  assign out_data = out_data_q;

endmodule

// File: tb/tb_psum_accumulator.sv
// tb_psum_accumulator
//   Scoreboard bench for psum_accumulator: the driver pushes the expected
//   result of each group (from an arithmetic reference model) into a
//   queue, and an independent monitor pops and compares whenever the DUT
//   presents an output. Honours PSUM_ACC_RELU_EN in the reference model.
module tb_psum_accumulator;
  import drlp_pkg::*;

  localparam int DW = DATA_WIDTH_DEF;
  localparam int PW = PSUM_WIDTH_DEF;
  localparam int NW = 8;
  localparam int SW = 5;
  localparam longint MAXV = (longint'(1) << (DW - 1)) - 1;
  localparam longint MINV = -(longint'(1) << (DW - 1));

  typedef struct {
    longint data;
    longint cyc;
  } exp_t;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clear;
  logic        [NW-1:0] cfg_num_pass;
  logic        [SW-1:0] cfg_shift;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [PW-1:0] in_psum;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [DW-1:0] out_data;

  exp_t   expQ[$];
  int     checks   = 0;
  int     failures = 0;
  longint cycleCnt = 0;
  int     beatVals[0:7];
  bit     forceLow  = 1'b0;
  bit     randReady = 1'b0;

  psum_accumulator dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .cfg_num_pass (cfg_num_pass),
    .cfg_shift    (cfg_shift),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_psum      (in_psum),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycleCnt <= cycleCnt + 1;

  // Consumer: ready is driven a little after the edge so the stimulus
  // process can change the mode flags first.
  initial out_ready = 1'b1;
  always @(posedge clk) begin
    #2;
    if (forceLow) out_ready = 1'b0;
    else if (randReady) out_ready = ($urandom_range(0, 3) != 0);
    else out_ready = 1'b1;
  end

  task automatic checkOutput(input string name, input longint actual, input longint required);
    checks++;
    if (actual != required) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d required=%0d at cycle %0d", name, actual, required, cycleCnt);
    end
  endtask

  // Round-half-up division by 2^sh, then clamp, then optional rectify.
  function automatic longint modelRequant(input longint s, input int sh);
    longint q, d, t;
    if (sh == 0) begin
      q = s;
    end else begin
      d = longint'(1) << sh;
      t = s + d / 2;
      q = t / d;
      if ((t % d != 0) && (t < 0)) q = q - 1;
    end
    if (q > MAXV) q = MAXV;
    if (q < MINV) q = MINV;
`ifdef PSUM_ACC_RELU_EN
    if (q < 0) q = 0;
`endif
    return q;
  endfunction

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic driveBeat(input int val, input int numPass, input int shiftVal,
                           output bit ok, output longint accCyc);
    ok = 1'b0;
    accCyc = 0;
    in_valid = 1'b1;
    in_psum = PW'(val);
    cfg_num_pass = NW'(numPass);
    cfg_shift = SW'(shiftVal);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        accCyc = cycleCnt + 1;
      end else begin
        in_psum = PW'($urandom);
      end
      @(posedge clk);
      #1;
      if (ok) break;
      in_psum = PW'(val);
    end
    if (!ok) begin
      checks++;
      failures++;
      $display("[TB] FAIL beat_accept_timeout actual=0 required=1");
    end
  endtask

  task automatic applyStimulus(input int numPass, input int shiftVal);
    int n;
    longint sum, c;
    bit ok;
    n = (numPass == 0) ? 1 : numPass;
    sum = 0;
    c = 0;
    for (int i = 0; i < n; i++) begin
      if (i == 0) driveBeat(beatVals[i], numPass, shiftVal, ok, c);
      else driveBeat(beatVals[i], int'($urandom_range(0, 255)), int'($urandom_range(0, 31)), ok, c);
      if (!ok) begin
        in_valid = 1'b0;
        return;
      end
      sum += beatVals[i];
    end
    in_valid = 1'b0;
    expQ.push_back('{modelRequant(sum, shiftVal), c});
  endtask

  task automatic runOne(input int val, input int numPass, input int shiftVal);
    beatVals[0] = val;
    applyStimulus(numPass, shiftVal);
  endtask

  task automatic waitDrain();
    for (int i = 0; i < 300; i++) begin
      if (expQ.size() == 0 && !out_valid) break;
      @(posedge clk);
      #1;
    end
  endtask

  // Abort a 3-pass group after two beats, by clear or by reset.
  task automatic abortGroup(input bit useReset);
    bit ok;
    longint c;
    waitDrain();
    driveBeat(50, 3, 0, ok, c);
    driveBeat(60, 1, 4, ok, c);
    in_valid = 1'b1;
    in_psum = PW'(77);
    if (useReset) rst_n = 1'b0;
    else clear = 1'b1;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    clear = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    checkOutput(useReset ? "abort_rst_ready" : "abort_clr_ready", in_ready, 1);
    checkOutput(useReset ? "abort_rst_valid" : "abort_clr_valid", out_valid, 0);
    @(posedge clk);
    #1;
    for (int i = 0; i < 3; i++) beatVals[i] = 1;
    applyStimulus(3, 0);
  endtask

  // Monitor: pops one expectation per presented result and checks that a
  // stalled result stays put.
  bit pending = 1'b0;
  longint heldData = 0;
  always @(negedge clk) begin
    exp_t e;
    if (out_valid) begin
      if (!pending) begin
        if (expQ.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_output actual=%0d required=none", out_data);
        end else begin
          e = expQ.pop_front();
          checkOutput("out_data", out_data, e.data);
          checkOutput("out_latency", cycleCnt, e.cyc);
        end
        heldData = out_data;
      end else begin
        checkOutput("hold_stable", out_data, heldData);
      end
      checkOutput("ready_valid_excl", in_ready, 0);
      pending = !out_ready;
    end else begin
      pending = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL global_timeout actual=running required=finished");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    bit seen;
    rst_n = 1'b0;
    clear = 1'b0;
    in_valid = 1'b0;
    in_psum = '0;
    cfg_num_pass = '0;
    cfg_shift = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_out_data", out_data, 0);
    rst_n = 1'b1;
    @(negedge clk);
    checkOutput("reset_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] directed groups");
    runOne(100, 1, 0);
    beatVals[0] = 10; beatVals[1] = 20; beatVals[2] = 30;
    applyStimulus(3, 2);
    runOne(1000, 1, 0);
    runOne(-1000, 1, 0);
    runOne(-6, 1, 2);
    runOne(5, 1, 1);
    runOne(7, 0, 0);
    runOne(2097151, 1, 0);
    runOne(-2097152, 1, 31);
    waitDrain();

    $display("[TB] backpressure");
    forceLow = 1'b1;
    runOne(42, 1, 0);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_psum = PW'($urandom);
      @(negedge clk);
      checkOutput("stall_in_ready", in_ready, 0);
      checkOutput("stall_out_valid", out_valid, 1);
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    forceLow = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid && out_ready) begin
        seen = 1'b1;
        break;
      end
    end
    checkOutput("release_handshake", seen, 1);
    @(negedge clk);
    checkOutput("release_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    $display("[TB] aborts");
    abortGroup(1'b0);
    abortGroup(1'b1);
    waitDrain();

    $display("[TB] random groups");
    randReady = 1'b1;
    for (int g = 0; g < 60; g++) begin
      int np;
      np = int'($urandom_range(0, 5));
      for (int i = 0; i < 8; i++) begin
        if ($urandom_range(0, 1) == 1) beatVals[i] = int'($urandom_range(0, 600)) - 300;
        else beatVals[i] = int'($urandom_range(0, (1 << PW) - 1)) - (1 << (PW - 1));
      end
      applyStimulus(np, int'($urandom_range(0, 12)));
    end
    randReady = 1'b0;
    waitDrain();
    checkOutput("queue_drained", expQ.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
